// File: rtl/gate_pkg.sv
// Shared opcode map and result-tag types for the gate arbiter and its logic unit.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT     = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  // Sideband carried alongside each registered result.
  typedef struct packed {
    logic id;
    logic err;
  } res_tag_t;

endpackage

// File: rtl/gate_logic_unit.sv
// Purely combinational W-bit bitwise logic unit shared by both requesters.
module gate_logic_unit
  import gate_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    y,
  output logic            err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter feeding one shared logic unit, with a single registered
// result stage and per-requester delivered-result counters.
module gate_op_arbiter
  import gate_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_id,
  output logic             res_err,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  logic            rr;
  logic            accept_en_c;
  logic            grant0_c;
  logic            grant1_c;
  logic            handshake_c;
  logic            consume_c;
  logic [OP_W-1:0] sel_op_c;
  logic [W-1:0]    sel_a_c;
  logic [W-1:0]    sel_b_c;
  logic [W-1:0]    lu_y_c;
  logic            lu_err_c;
  res_tag_t        tag_q;

  // Output stage can take a new result when empty or being drained this cycle.
  assign accept_en_c = !res_valid || res_ready;
  assign consume_c   = res_valid && res_ready;

  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (accept_en_c) begin
      if (req0_valid && req1_valid) begin
        grant0_c = !rr;
        grant1_c = rr;
      end else begin
        grant0_c = req0_valid;
        grant1_c = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0_c;
  assign req1_ready  = grant1_c;
  assign handshake_c = grant0_c || grant1_c;

  // Operand mux in front of the single shared datapath.
  always_comb begin
    sel_op_c = req0_op;
    sel_a_c  = req0_a;
    sel_b_c  = req0_b;
    if (grant1_c) begin
      sel_op_c = req1_op;
      sel_a_c  = req1_a;
      sel_b_c  = req1_b;
    end
  end

  gate_logic_unit #(.W(W)) u_lu (
    .op  (sel_op_c),
    .a   (sel_a_c),
    .b   (sel_b_c),
    .y   (lu_y_c),
    .err (lu_err_c)
  );

  // Result register; a new grant overwrites a result consumed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      tag_q     <= '0;
      rr        <= 1'b0;
    end else if (handshake_c) begin
      res_valid <= 1'b1;
      res_data  <= lu_y_c;
      tag_q.id  <= grant1_c;
      tag_q.err <= lu_err_c;
      rr        <= grant0_c;
    end else if (consume_c) begin
      res_valid <= 1'b0;
    end
  end

  assign res_id  = tag_q.id;
  assign res_err = tag_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (consume_c) begin
      if (tag_q.id) done_cnt1 <= done_cnt1 + CNT_W'(1);
      else          done_cnt0 <= done_cnt0 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: reference model pushes expected results,
// an independent monitor pops and compares them as the DUT presents results.
module tb_gate_op_arbiter;
  import gate_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [OP_W-1:0]  req0_op = '0, req1_op = '0;
  logic [W-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [W-1:0]     res_data;
  logic             res_id, res_err;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  gate_op_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
    logic         err;
  } exp_t;

  exp_t             sb[$];
  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;

  // Reference model state: occupancy, tie-break owner, held result owner, counts.
  logic             m_full, m_rr, m_id;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  logic             hs0 = 1'b0, hs1 = 1'b0;
  logic             e_acc, e_g0, e_g1;
  exp_t             e_new;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_lu(input logic [OP_W-1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  // Model: predicts grants, checks readies/occupancy/counters, enqueues results.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_full = 1'b0; m_rr = 1'b0; m_id = 1'b0;
      m_cnt0 = '0;   m_cnt1 = '0;
      hs0 = 1'b0;    hs1 = 1'b0;
      sb.delete();
    end else begin
      e_acc = !m_full || res_ready;
      e_g0  = 1'b0;
      e_g1  = 1'b0;
      if (e_acc) begin
        if (req0_valid && req1_valid) begin
          if (m_rr) e_g1 = 1'b1;
          else      e_g0 = 1'b1;
        end else begin
          e_g0 = req0_valid;
          e_g1 = req1_valid;
        end
      end
      check("req0_ready", 32'(req0_ready), 32'(e_g0));
      check("req1_ready", 32'(req1_ready), 32'(e_g1));
      check("res_valid",  32'(res_valid),  32'(m_full));
      check("done_cnt0",  32'(done_cnt0),  32'(m_cnt0));
      check("done_cnt1",  32'(done_cnt1),  32'(m_cnt1));
      hs0 = e_g0;
      hs1 = e_g1;
      if (m_full && res_ready) begin
        if (m_id) m_cnt1 = m_cnt1 + 1'b1;
        else      m_cnt0 = m_cnt0 + 1'b1;
      end
      if (e_g0 || e_g1) begin
        e_new.id   = e_g1;
        e_new.data = e_g1 ? ref_lu(req1_op, req1_a, req1_b) : ref_lu(req0_op, req0_a, req0_b);
        e_new.err  = e_g1 ? (req1_op == 3'd7) : (req0_op == 3'd7);
        sb.push_back(e_new);
        m_full = 1'b1;
        m_id   = e_g1;
        m_rr   = e_g0;
      end else if (res_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        check("res_valid_unexpected", 32'(res_valid), 32'd0);
      end else begin
        check("res_data", 32'(res_data), 32'(sb[0].data));
        check("res_id",   32'(res_id),   32'(sb[0].id));
        check("res_err",  32'(res_err),  32'(sb[0].err));
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  logic [7:0]       sweep_exp [7];
  logic [7:0]       held;
  logic [CNT_W-1:0] c0_base, c1_base;

  initial begin
    sweep_exp = '{8'h05, 8'hAF, 8'h50, 8'h5A, 8'hFA, 8'hAA, 8'h55};

    // Reset values
    repeat (2) step();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_cnt0",      32'(done_cnt0), 32'd0);
    rst_n = 1'b1;
    step();

    // First request from requester 0
    res_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 8'hF0, 8'h3C);
    #1 check("first_ready", 32'(req0_ready), 32'd1);
    step();
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("first_data", 32'(res_data), 32'h30);
    check("first_id",   32'(res_id),   32'd0);
    step();
    check("first_cnt0", 32'(done_cnt0), 32'd1);

    // Opcode sweep from requester 1, back to back
    for (int i = 0; i < 7; i++) begin
      set_req(1, 1'b1, 3'(i), 8'hA5, 8'h0F);
      step();
      check("sweep_data",  32'(res_data),  32'(sweep_exp[i]));
      check("sweep_valid", 32'(res_valid), 32'd1);
    end
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    step();

    // Continuous contention alternates grants
    c0_base = done_cnt0;
    c1_base = done_cnt1;
    set_req(0, 1'b1, 3'd5, 8'h12, 8'h34);
    set_req(1, 1'b1, 3'd1, 8'h56, 8'h78);
    for (int i = 0; i < 8; i++) begin
      step();
      check("alt_id", 32'(res_id), 32'(i % 2));
    end
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    check("alt_cnt0", 32'(done_cnt0 - c0_base), 32'd4);
    check("alt_cnt1", 32'(done_cnt1 - c1_base), 32'd4);

    // Back-pressure stall with both requesters waiting
    set_req(0, 1'b1, 3'd4, 8'hC3, 8'h0F);
    set_req(1, 1'b1, 3'd6, 8'h99, 8'h66);
    step();
    res_ready = 1'b0;
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", 32'(res_data), 32'(held));
      check("stall_rdy",  32'(req0_ready | req1_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    step();
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    step();

    // Illegal opcode
    c0_base = done_cnt0;
    set_req(0, 1'b1, 3'd7, 8'hFF, 8'hFF);
    step();
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("ill_data", 32'(res_data), 32'd0);
    check("ill_err",  32'(res_err),  32'd1);
    step();
    check("ill_cnt0", 32'(done_cnt0 - c0_base), 32'd1);

    // Reset while a result is held
    set_req(0, 1'b1, 3'd1, 8'h0F, 8'hF0);
    set_req(1, 1'b1, 3'd2, 8'h0F, 8'hF0);
    res_ready = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(res_valid), 32'd0);
    check("rst_mid_cnt0",  32'(done_cnt0), 32'd0);
    check("rst_mid_cnt1",  32'(done_cnt1), 32'd0);
    step();
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1 check("rst_first_grant", 32'(req0_ready), 32'd1);
    step();
    check("rst_first_id", 32'(res_id), 32'd0);
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    step();

    // Randomized traffic; unaccepted commands are held stable
    for (int i = 0; i < 600; i++) begin
      if (!(req0_valid && !hs0))
        set_req(0, 1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
      if (!(req1_valid && !hs1))
        set_req(1, 1'($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom), 8'($urandom));
      res_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // Drain
    set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    res_ready = 1'b1;
    repeat (4) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Two-requester arbiter and sequencer for a shared W-bit bitwise logic unit.
- The logic unit computes AND, OR, NOR, NOT, NAND, XOR and XNOR.
- Each requester issues {op, a, b} on a valid/ready handshake. The block grants one request per cycle using round-robin, evaluates the operation, and returns it through a single registered result channel tagged with the requester ID.
- Sits between software-visible command ports and the shared gate datapath, so the gate datapath is never duplicated.

Parameters:
- W, 8, operand/result width in bits.
- CNT_W, 16, width of the per-requester completed-operation counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  3  requester 0 opcode.
- req0_a  input  W  requester 0 operand a.
- req0_b  input  W  requester 0 operand b.
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same directions and widths as requester 0, for requester 1.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  W  operation result.
- res_id  output  1  requester that issued the result.
- res_err  output  1  the opcode was illegal.
- done_cnt0  output  CNT_W  results delivered to requester 0.
- done_cnt1  output  CNT_W  results delivered to requester 1.

Behaviour:
- Reset (async, rst_n=0):
  - res_valid=0, res_data=0, res_id=0, res_err=0.
  - done_cnt0=done_cnt1=0.
  - Round-robin pointer rr=0, meaning requester 0 has priority.
  - Effect is immediate, with no clock edge required.
- Reset mid-operation discards any held result. After release, the first accepted request is arbitrated fresh with rr=0.
- accept_en = !res_valid || res_ready. This is a single output stage and supports back-to-back operation at one op per cycle.
- Grant is combinational and taken only when accept_en=1:
  - One requester valid: that requester is granted.
  - Both valid: requester rr is granted.
  - reqN_ready = accept_en && grant==N.
  - At most one ready is high per cycle.
  - ready never depends on the same requester's valid being low.
- On a handshake (reqN_valid && reqN_ready), at the next rising edge:
  - res_valid=1.
  - res_data = LU(op, a, b).
  - res_id = N.
  - res_err = (op==7).
  - rr = ~N, so the other requester wins the next tie.
- Latency: a request accepted in cycle t is visible on res_* in cycle t+1.
- rr changes only on a grant. An uncontested grant still toggles rr to the other requester.
- Opcode map, bitwise over W:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 NOR: ~(a|b)
  - 3 NOT: ~a, b ignored
  - 4 NAND: ~(a&b)
  - 5 XOR: a^b
  - 6 XNOR: ~(a^b)
  - 7 illegal: res_data=0, res_err=1. The result is still delivered and still counted.
- res_* stay stable while res_valid && !res_ready.
- If res_valid && res_ready and no new grant: res_valid falls to 0 at the next edge. res_data/res_id/res_err hold their last values.
- Simultaneous res_ready and a new grant: the new result replaces the old one on the same edge, with no bubble.
- Counters:
  - done_cntN increments when res_valid && res_ready && res_id==N.
  - They wrap modulo 2^CNT_W silently.
- Input requirement: requesters must hold op/a/b stable while valid && !ready. The block does not register unaccepted commands.
- No FSM beyond the output-stage occupancy bit (EMPTY/FULL = res_valid) and the rr bit.

Decomposition:
- Shared package gate_pkg holds:
  - opcode localparams OP_AND..OP_XNOR=0..6 and OP_ILLEGAL=7
  - the op width constant 3
- Sub-module gate_logic_unit is purely combinational.
  - Inputs: op, a, b. Outputs: y, err.
  - Parameterised by W, instantiated once.
- The arbiter, output register and counters live in gate_op_arbiter.

Test Plan:
- Reset, then req0 op=0 a=8'hF0 b=8'h3C, res_ready=1: req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=8'h30, res_id=0, res_err=0; done_cnt0=1 one cycle later.
- Sweep ops 0..6 from req1 with a=8'hA5 b=8'h0F, res_ready=1: results 05, AF, 50, 5A, FA, AA, 55 on consecutive cycles with res_id=1 and no bubbles.
- Both requesters valid continuously, res_ready=1: grants alternate 0,1,0,1; done_cnt0=done_cnt1=4 after 8 results.
- res_ready=0 for 5 cycles with both requesters valid: exactly one result is held stable, both readies stay 0, and rr is unchanged. When res_ready rises, the held result is consumed and the next request is granted in the same cycle.
- op=7 from req0: res_data=0, res_err=1, done_cnt0 increments.
- Assert rst_n low while res_valid=1 and res_ready=0: res_valid drops immediately and the counters clear. After release, with both requesters valid, requester 0 is granted first.
